// File: rtl/serial_adder_scheduler.sv
// Two-requester bit-serial adder: one shared full-adder cell, round-robin grant, LSB first.
//   state | meaning
//   IDLE  | arbitrate; load granted operands on the accept edge
//   ADD   | one sum bit per clock through the shared cell
//   HOLD  | result presented until rsp_ready
module serial_adder_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic grant0, grant1;
  logic bit_s, bit_c;

  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = (state_q == IDLE) & grant0;
    req1_ready = (state_q == IDLE) & grant1;

    bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_valid_d  = rsp_valid_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          a_d          = grant1 ? req1_a : req0_a;
          b_d          = grant1 ? req1_b : req0_b;
          carry_d      = grant1 ? req1_cin : req0_cin;
          cnt_d        = '0;
          rsp_id_d     = grant1;
          last_grant_d = grant1;
          busy_d       = 1'b1;
          state_d      = ADD;
        end
      end
      ADD: begin
        // sum fills from the top, so after WIDTH shifts bit 0 sits at the LSB
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = bit_c;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          rsp_cout_d  = bit_c;
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_adder_scheduler.sv
// Directed and random checks of serial_adder_scheduler at WIDTH=4.
module tb_serial_adder_scheduler;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_s;

  int n_pass  = 0;
  int n_total = 0;

  serial_adder_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one lone request, check result, then take it.
  task automatic do_op(input string tag, input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec);
    @(posedge clk); #1;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
    @(negedge clk);
    chk({tag, "_ready"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    wait_rsp(tag);
    chk({tag, "_s"}, rsp_s, es);
    chk({tag, "_cout"}, rsp_cout, ec);
    chk({tag, "_id"}, rsp_id, id);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    chk({tag, "_taken"}, {rsp_valid, busy}, 2'b00);
  endtask

  logic [5:0] exp_q[$];
  logic [5:0] e;
  logic [4:0] full;
  int acc_cnt, rsp_cnt, cyc;
  logic hold_s_ok;

  initial begin
    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    #12;
    chk("rst_outs", {rsp_valid, busy, rsp_s, rsp_cout, rsp_id}, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1 rst_n = 1;

    // Latency: accept at edge k, rsp_valid only after edge k+4
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 4'b0101; req0_b = 4'b0011; req0_cin = 0;
    @(negedge clk);
    chk("lat_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("lat_busy", {busy, rsp_valid, req0_ready}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("lat_early", rsp_valid, 1'b0);
    end
    @(posedge clk); @(negedge clk);
    chk("lat_valid", rsp_valid, 1'b1);
    chk("lat_s", rsp_s, 4'b1000);
    chk("lat_cout", rsp_cout, 1'b0);
    chk("lat_id", rsp_id, 1'b0);
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    chk("lat_idle", {rsp_valid, busy}, 2'b00);

    do_op("r1_wrap", 1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    do_op("r1_full", 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
    do_op("r0_cin",  1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0);

    // Round robin after reset: both valid, consumer always ready
    rst_n = 0; #2 rst_n = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3; req0_cin = 1;
    req1_valid = 1; req1_a = 4'd9; req1_b = 4'd9; req1_cin = 0;
    rsp_ready = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rr_grant", {req1_ready, req0_ready}, (n % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); @(negedge clk);
      wait_rsp("rr");
      chk("rr_id", rsp_id, n % 2);
      chk("rr_s", {rsp_cout, rsp_s}, (n % 2 == 0) ? 5'd6 : 5'd18);
      chk("rr_noaccept", {req1_ready, req0_ready}, 2'b00);
      @(posedge clk);
    end
    #1 req0_valid = 0; req1_valid = 0; rsp_ready = 0;

    // HOLD stall while request inputs wiggle
    do_op("pre", 1'b0, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 4'd12; req0_b = 4'd7; req0_cin = 1;
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    wait_rsp("hold");
    hold_s_ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req0_valid = 1; req1_valid = 1;
      req0_a = 4'(i); req1_a = 4'(i + 5); req0_b = 4'(i * 3); req1_cin = i[0];
      @(negedge clk);
      chk("hold_rsp", {rsp_valid, busy, rsp_id, rsp_cout, rsp_s}, {1'b1, 1'b1, 1'b0, 1'b1, 4'd4});
      chk("hold_ready", {req1_ready, req0_ready}, 2'b00);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    chk("hold_release", {rsp_valid, busy}, 2'b00);

    // Reset two cycles into ADD, then req0 waiting across release
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 4'd3; req1_b = 4'd4; req1_cin = 0;
    @(posedge clk); #1 req1_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    rst_n = 0;
    req0_valid = 1; req0_a = 4'd6; req0_b = 4'd7; req0_cin = 0;
    #1;
    chk("mid_rst", {rsp_valid, busy, rsp_s, rsp_cout, rsp_id}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("mid_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    wait_rsp("mid");
    chk("mid_sum", {rsp_id, rsp_cout, rsp_s}, {1'b0, 5'd13});
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;

    // Random sweep with scoreboard
    acc_cnt = 0; rsp_cnt = 0; cyc = 0;
    while (cyc < 40000 && !(acc_cnt >= 1000 && rsp_cnt == acc_cnt && !req0_valid && !req1_valid)) begin
      @(negedge clk);
      if (req0_ready) begin
        full = {1'b0, req0_a} + {1'b0, req0_b} + {4'd0, req0_cin};
        exp_q.push_back({1'b0, full});
        acc_cnt++;
      end
      if (req1_ready) begin
        full = {1'b0, req1_a} + {1'b0, req1_b} + {4'd0, req1_cin};
        exp_q.push_back({1'b1, full});
        acc_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("sw_extra", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sw_id", rsp_id, e[5]);
          chk("sw_sum", {rsp_cout, rsp_s}, e[4:0]);
        end
        rsp_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (req0_ready || !req0_valid) begin
        req0_valid = (acc_cnt < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_cin = 1'($urandom);
      end
      if (req1_ready || !req1_valid) begin
        req1_valid = (acc_cnt < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_cin = 1'($urandom);
      end
      rsp_ready = 1'($urandom_range(0, 1));
    end
    chk("sw_done", cyc < 40000, 1'b1);
    chk("sw_count", rsp_cnt, acc_cnt);
    chk("sw_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_adder_scheduler.md
Name: serial_adder_scheduler

Overview:
Shares a single 1-bit full-adder cell between two requesters. Each request is a WIDTH-bit addition, executed bit-serially, LSB first, one bit per clock. A round-robin arbiter grants the next request. An FSM sequences the operand shift registers, the carry register and the bit counter, then holds the result until the consumer takes it. This block is the time-multiplexed alternative to a ripple chain of full adders.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an addition pending
req0_ready  output  1  requester 0 request accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_cin  input  1  requester 0 carry-in
req1_valid  input  1  requester 1 has an addition pending
req1_ready  output  1  requester 1 request accepted this cycle
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_cin  input  1  requester 1 carry-in
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes the result
rsp_s  output  WIDTH  sum
rsp_cout  output  1  final carry-out
rsp_id  output  1  index of the requester that owns the result
busy  output  1  high in ADD or HOLD

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rsp_valid=0, rsp_s=0, rsp_cout=0, rsp_id=0, busy=0, carry=0, counter=0, last_grant=1 (so requester 0 wins the first tie).
- FSM states: IDLE, ADD, HOLD.
- IDLE, grant rule:
  - grant0 = req0_valid & (~req1_valid | last_grant==1).
  - grant1 = req1_valid & (~req0_valid | last_grant==0).
  - reqN_ready = (state==IDLE) & grantN. This is combinational from valid; at most one ready is high.
- IDLE, on a grant at a clock edge:
  - Load the operand shift registers from the granted a and b.
  - Set carry = granted cin, counter = 0, rsp_id = granted index, last_grant = granted index.
  - Go to ADD.
- ADD, each cycle:
  - The bit cell computes s = a0^b0^carry and c = majority(a0,b0,carry) from the shift-register LSBs.
  - s shifts into the MSB of the sum register (right shift); c is registered into carry.
  - Both operand registers shift right; counter increments.
  - When counter==WIDTH-1, that edge goes to HOLD; rsp_cout takes the final c and rsp_s holds the complete sum.
- Latency: request accepted at edge k; rsp_valid rises after edge k+WIDTH.
- HOLD: rsp_valid=1. rsp_s, rsp_cout and rsp_id stay stable while rsp_ready=0. On an edge with rsp_ready=1, go to IDLE and clear rsp_valid.
- No new request is accepted in the same cycle the response is taken; the earliest next accept is the edge after return to IDLE.
- Request inputs are ignored outside IDLE. Requesters must hold valid and operands stable until ready.
- Arithmetic: the result equals (a+b+cin) mod 2^WIDTH; cout is bit WIDTH of the full sum. No overflow flag.
- Reset mid-operation: an ADD or HOLD in progress is discarded with no response, and all outputs return to reset values immediately (asynchronously).
- rsp_ready high while not in HOLD: ignored.

Test Plan:
- WIDTH=4; req0 a=0101 b=0011 cin=0 -> req0_ready for 1 cycle; rsp_valid after 4 edges; rsp_s=1000, rsp_cout=0, rsp_id=0.
- req1 a=1111 b=0001 cin=0 -> rsp_s=0000, rsp_cout=1, rsp_id=1. Then a=1111 b=1111 cin=1 -> rsp_s=1111, rsp_cout=1.
- Both valid continuously with rsp_ready=1, 4 back-to-back ops -> rsp_id sequence 0,1,0,1; first grant goes to req0 after reset.
- In HOLD, hold rsp_ready=0 for 3 cycles while changing req inputs -> rsp_s, rsp_cout, rsp_id unchanged, both readys 0, busy=1. rsp_ready=1 -> IDLE next edge, rsp_valid=0.
- Assert rst_n=0 two cycles into ADD -> rsp_valid=0, busy=0 immediately. After release with req0 pending -> req0 granted, correct sum produced.
- Random sweep of 1000 additions, both requesters, random rsp_ready -> every rsp_s/rsp_cout matches a+b+cin. Each response is delivered exactly once and tagged with the correct rsp_id.
